// File: rtl/pcie_mac_pkg.sv
// Shared PCIe MAC definitions: 128b/130b sync header encodings, block type and framer state.
package pcie_mac_pkg;

    localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
    localparam logic [1:0] SYNC_HDR_OS   = 2'b10;

    typedef enum logic {BLK_DATA = 1'b0, BLK_OS = 1'b1} block_type_e;
    typedef enum logic {IDLE, IN_BLOCK} framer_state_e;

    // Only the two legal headers can ever come out of this mapping.
    function automatic logic [1:0] sync_hdr_for(input block_type_e blk);
        return (blk == BLK_OS) ? SYNC_HDR_OS : SYNC_HDR_DATA;
    endfunction

endpackage

// File: rtl/tx_beat_counter.sv
// Modulo-BEATS beat counter with synchronous clear; flags the first and last beat of a block.
module tx_beat_counter #(
    parameter int unsigned BEATS = 4
) (
    input  logic CLK,
    input  logic RST_L,
    input  logic inc,
    input  logic clear,
    output logic first,
    output logic last
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    assign first = (count == '0);
    assign last  = (count == CNT_W'(BEATS - 1));

endmodule

// File: rtl/tx_block_framer.sv
// TX 128b/130b block framer for one lane: groups accepted beats into 128-bit blocks and tags
// each block start with its sync header and block type.
module tx_block_framer
    import pcie_mac_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_L,
    input  logic [DATA_W-1:0] TX_Data_In,
    input  logic              TX_Data_Valid,
    input  logic              TX_OS_Req,
    input  logic              TX_Stall,
    input  logic              TX_Flush,
    output logic              TX_Ready,
    output logic [DATA_W-1:0] TX_Data_Out,
    output logic              TX_Data_Valid_Out,
    output logic              TX_Start_Block,
    output logic [0:1]        TX_Sync_Header,
    output logic              TX_Block_Type,
    output logic              TX_Flush_Err
);

    localparam int unsigned BEATS_PER_BLOCK = 128 / DATA_W;

    framer_state_e state;
    block_type_e   blk_type;
    block_type_e   req_type;
    logic          accept;
    logic          cnt_first;
    logic          cnt_last;

    assign TX_Ready      = !TX_Stall;
    assign accept        = TX_Data_Valid && TX_Ready;
    assign TX_Block_Type = blk_type;

    always_comb begin
        req_type = TX_OS_Req ? BLK_OS : BLK_DATA;
    end

    // Flush wins over accept, so the counter only advances on a beat that is actually kept.
    tx_beat_counter #(
        .BEATS(BEATS_PER_BLOCK)
    ) u_beat_counter (
        .CLK  (CLK),
        .RST_L(RST_L),
        .inc  (accept && !TX_Flush),
        .clear(TX_Flush),
        .first(cnt_first),
        .last (cnt_last)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state             <= IDLE;
            blk_type          <= BLK_DATA;
            TX_Data_Out       <= '0;
            TX_Data_Valid_Out <= 1'b0;
            TX_Start_Block    <= 1'b0;
            TX_Sync_Header    <= 2'b00;
            TX_Flush_Err      <= 1'b0;
        end else begin
            TX_Flush_Err <= 1'b0;
            if (TX_Flush) begin
                // A non-zero beat count is exactly "partial block in flight".
                TX_Flush_Err      <= !cnt_first;
                TX_Data_Valid_Out <= 1'b0;
                TX_Start_Block    <= 1'b0;
                state             <= IDLE;
            end else if (accept) begin
                TX_Data_Out       <= TX_Data_In;
                TX_Data_Valid_Out <= 1'b1;
                case (state)
                    IDLE: begin
                        TX_Start_Block <= 1'b1;
                        blk_type       <= req_type;
                        TX_Sync_Header <= sync_hdr_for(req_type);
                        state          <= cnt_last ? IDLE : IN_BLOCK;
                    end
                    IN_BLOCK: begin
                        TX_Start_Block <= 1'b0;
                        if (cnt_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                TX_Data_Valid_Out <= 1'b0;
                TX_Start_Block    <= 1'b0;
            end
        end
    end

endmodule
